// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: read pointer, EMPTY flag and a one-word FWFT output stage.
// Optional feature macro: FIFO_RD_GRAY_EN (Gray-coded read pointer export; binary copy when undefined).
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  input  logic [ADDR_WIDTH:0]   write_addr_sync,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [ADDR_WIDTH:0]   read_addr,
  output logic [ADDR_WIDTH:0]   read_addr_gray,
  output logic                  EMPTY_flag,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  state_dbg
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t              state;
  logic                pop;
  logic [ADDR_WIDTH:0] next_addr;
  logic [ADDR_WIDTH:0] next_gray;

  // Handshake: a word moves to the consumer on any edge where rd_valid && rd_ready;
  // rd_valid is held (with rd_data stable) until that happens.
  assign EMPTY_flag = (read_addr == write_addr_sync);
  assign pop        = !EMPTY_flag && (!rd_valid || rd_ready);
  assign next_addr  = read_addr + PTR_ONE;
  assign mem_raddr  = read_addr[ADDR_WIDTH-1:0];
  assign state_dbg  = (state == S_FULL);

`ifdef FIFO_RD_GRAY_EN
  assign next_gray = next_addr ^ (next_addr >> 1);
`else
  assign next_gray = next_addr;
`endif

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state          <= S_EMPTY;
      rd_valid       <= 1'b0;
      rd_data        <= '0;
      read_addr      <= '0;
      read_addr_gray <= '0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (pop) begin
            state          <= S_FULL;
            rd_valid       <= 1'b1;
            rd_data        <= mem_rdata;
            read_addr      <= next_addr;
            read_addr_gray <= next_gray;
          end
        end
        S_FULL: begin
          if (pop) begin
            // Consumer took the old word this edge; the next one replaces it.
            rd_data        <= mem_rdata;
            read_addr      <= next_addr;
            read_addr_gray <= next_gray;
          end else if (rd_ready) begin
            state    <= S_EMPTY;
            rd_valid <= 1'b0;
          end
        end
        default: begin
          state    <= S_EMPTY;
          rd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: memory + write-pointer model, data scoreboard, per-cycle rule checker.
module tb_fifo_rd_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;

  // clock / reset
  logic          r_clk = 1'b0;
  logic          r_rst = 1'b1;
  always #5 r_clk = ~r_clk;

  logic [AW:0]   write_addr_sync = '0;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] mem_raddr;
  logic [AW:0]   read_addr;
  logic [AW:0]   read_addr_gray;
  logic          EMPTY_flag;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic          state_dbg;

  logic [DW-1:0] mem [16];
  assign mem_rdata = mem[mem_raddr];

  fifo_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .r_clk(r_clk), .r_rst(r_rst), .write_addr_sync(write_addr_sync),
    .mem_rdata(mem_rdata), .mem_raddr(mem_raddr), .read_addr(read_addr),
    .read_addr_gray(read_addr_gray), .EMPTY_flag(EMPTY_flag), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .state_dbg(state_dbg)
  );

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];
  int  n_xfer   = 0;
  bit  chk_en   = 1'b0;
  bit  saw_wrap = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW:0] exp_gray(input logic [AW:0] a);
`ifdef FIFO_RD_GRAY_EN
    return a ^ (a >> 1);
`else
    return a;
`endif
  endfunction

  // driver tasks
  task automatic step();
    @(posedge r_clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    mem[write_addr_sync[AW-1:0]] = d;
    exp_q.push_back(d);
    write_addr_sync = write_addr_sync + 5'd1;
  endtask

  // scoreboard + rule checker, sampled mid-cycle
  logic [AW:0]   p_ra;
  logic [DW-1:0] p_d;
  logic          p_v, p_e, p_rdy;
  bit            have_prev = 1'b0;

  always @(negedge r_clk) begin
    if (!chk_en) begin
      have_prev = 1'b0;
    end else begin
      check("empty_flag", int'(EMPTY_flag), int'(read_addr == write_addr_sync));
      check("gray", int'(read_addr_gray), int'(exp_gray(read_addr)));
      check("state_dbg", int'(state_dbg), int'(rd_valid));
      if (have_prev) begin
        if (!p_e && (!p_v || p_rdy)) begin
          check("pop_valid", int'(rd_valid), 1);
          check("pop_addr", int'(read_addr), int'(5'(p_ra + 5'd1)));
        end else if (p_v && !p_rdy) begin
          check("hold_valid", int'(rd_valid), 1);
          check("hold_data", int'(rd_data), int'(p_d));
          check("hold_addr", int'(read_addr), int'(p_ra));
        end else begin
          check("idle_valid", int'(rd_valid), 0);
          check("idle_addr", int'(read_addr), int'(p_ra));
        end
        if (p_ra == 5'd31 && read_addr == 5'd0) saw_wrap = 1'b1;
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          check("xfer_unexpected", 1, 0);
        end else begin
          check("xfer_data", int'(rd_data), int'(exp_q.pop_front()));
        end
        n_xfer++;
      end
      p_ra = read_addr; p_d = rd_data; p_v = rd_valid; p_e = EMPTY_flag; p_rdy = rd_ready;
      have_prev = 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, written;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);

    // reset state
    r_rst = 1'b1; write_addr_sync = '0;
    repeat (3) step();
    check("rst_read_addr", int'(read_addr), 0);
    check("rst_gray", int'(read_addr_gray), 0);
    check("rst_valid", int'(rd_valid), 0);
    check("rst_data", int'(rd_data), 0);
    check("rst_empty", int'(EMPTY_flag), 1);
    r_rst = 1'b0;
    step();
    chk_en = 1'b1;

    // single word, consumer stalled
    push_word(8'hA5);
    step();
    check("t2_valid", int'(rd_valid), 1);
    check("t2_data", int'(rd_data), 8'hA5);
    repeat (5) step();
    check("t2_hold_data", int'(rd_data), 8'hA5);
    check("t2_empty", int'(EMPTY_flag), 1);
    check("t2_addr", int'(read_addr), 1);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    step();
    check("t2_drained", int'(rd_valid), 0);
    check("t2_q_empty", exp_q.size(), 0);

    // reset raised between edges has no effect until the next edge
    chk_en = 1'b0;
    @(negedge r_clk);
    r_rst = 1'b1; write_addr_sync = '0;
    #1;
    check("async_rst_ignored", int'(read_addr), 1);
    step();
    check("sync_rst_addr", int'(read_addr), 0);
    check("sync_rst_empty", int'(EMPTY_flag), 1);
    r_rst = 1'b0;
    step();
    chk_en = 1'b1;

    // full memory, consumer always ready
    for (int i = 0; i < 16; i++) push_word(8'($urandom_range(0, 255)));
    rd_ready = 1'b1;
    base = n_xfer;
    repeat (18) step();
    check("t3_count", n_xfer - base, 16);
    check("t3_valid", int'(rd_valid), 0);
    check("t3_addr", int'(read_addr), 16);
    check("t3_gray", int'(read_addr_gray), int'(exp_gray(5'd16)));

    // 40 words, writer stepping one per cycle, random consumer
    written = 0;
    base = n_xfer;
    for (int c = 0; c < 3000 && (written < 40 || exp_q.size() != 0); c++) begin
      step();
      rd_ready = 1'($urandom_range(0, 1));
      if (written < 40 && 5'(write_addr_sync - read_addr) < 5'd16) begin
        push_word(8'($urandom_range(0, 255)));
        written++;
      end
    end
    check("t4_written", written, 40);
    check("t4_count", n_xfer - base, 40);
    check("t4_q_empty", exp_q.size(), 0);
    check("t4_wrap_seen", int'(saw_wrap), 1);

    // mid-stream reset with a word presented and five pending
    rd_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(8'($urandom_range(0, 255)));
    repeat (3) step();
    check("t5_valid_before", int'(rd_valid), 1);
    chk_en = 1'b0;
    r_rst = 1'b1; rd_ready = 1'b1;
    step();
    check("t5_valid", int'(rd_valid), 0);
    check("t5_addr", int'(read_addr), 0);
    check("t5_gray", int'(read_addr_gray), 0);
    check("t5_data", int'(rd_data), 0);
    check("t5_empty", int'(EMPTY_flag), int'(write_addr_sync == 5'd0));
    write_addr_sync = '0;
    exp_q.delete();
    step();
    r_rst = 1'b0;
    step();
    chk_en = 1'b1;

    // three words, pointer export tracked every cycle by the checker
    base = n_xfer;
    for (int i = 0; i < 3; i++) push_word(8'($urandom_range(0, 255)));
    repeat (6) step();
    check("t6_count", n_xfer - base, 3);
    check("t6_addr", int'(read_addr), 3);
    check("t6_gray", int'(read_addr_gray), int'(exp_gray(5'd3)));

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
